// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Two-requester round-robin arbiter and multi-cycle sequencer in front of
//   the shared combinational ALU. A granted operation is latched, the ALU is
//   driven from the latched operands for a per-opcode number of cycles, and
//   the ALU result is then held on a valid/ready response channel.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake, N = 0/1
//   reqN_op, reqN_a, reqN_b    requested opcode and operands
//   alu_a, alu_b, alu_op       drive to the ALU (idle: op 3'b111, operands 0)
//   alu_out, alu_r, alu_sign   ALU results
//   rsp_valid/ready            response handshake
//   rsp_id                     index of the requester being answered
//   rsp_out, rsp_r, rsp_sign   captured result, remainder/high half, sign
//   rsp_dz                     divide-by-zero flag
module alu_sequencer #(
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_sign,
    output logic             rsp_dz
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_IDLE = 3'b111;

    state_t           state, state_nx;
    logic             last_grant;
    logic [7:0]       cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;

    logic             any_valid;
    logic             gnt_id;
    logic             accept;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_dz;
    logic [7:0]       sel_lat;

    // Arbitration and operand selection. On a tie the requester that was
    // not granted last wins; last_grant resets to 1 so req0 wins first.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        gnt_id    = req1_valid & (~req0_valid | ~last_grant);
        accept    = (state == IDLE) & any_valid;
        // rst_n gating keeps ready low while reset is held, even with a
        // request pending against the reset IDLE state.
        req0_ready = rst_n & accept & ~gnt_id;
        req1_ready = rst_n & accept & gnt_id;
        sel_op = gnt_id ? req1_op : req0_op;
        sel_a  = gnt_id ? req1_a  : req0_a;
        sel_b  = gnt_id ? req1_b  : req0_b;
        sel_dz = (sel_op == OP_DIV) && (sel_b == '0);
        case (sel_op)
            OP_MUL:  sel_lat = 8'(MUL_LAT);
            OP_DIV:  sel_lat = 8'(DIV_LAT);
            default: sel_lat = 8'd1;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = sel_dz ? DONE : EXEC;
            EXEC: if (cnt == 8'd0) state_nx = DONE;
            DONE: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == DONE);
        alu_op    = OP_IDLE;
        alu_a     = '0;
        alu_b     = '0;
        if (state == EXEC) begin
            alu_op = op_q;
            alu_a  = a_q;
            alu_b  = b_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            cnt        <= '0;
            op_q       <= OP_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_out    <= '0;
            rsp_r      <= '0;
            rsp_sign   <= 1'b0;
            rsp_dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= gnt_id;
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        id_q       <= gnt_id;
                        cnt        <= sel_lat - 8'd1;
                        // Divide by zero bypasses the ALU entirely.
                        if (sel_dz) begin
                            rsp_id   <= gnt_id;
                            rsp_out  <= '1;
                            rsp_r    <= sel_a;
                            rsp_sign <= 1'b1;
                            rsp_dz   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 8'd0) begin
                        rsp_id   <= id_q;
                        rsp_out  <= alu_out;
                        rsp_r    <= alu_r;
                        rsp_sign <= alu_sign;
                        rsp_dz   <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
